udp_table_sched: RTL and testbench
==================================

// Module: udp_table_sched
// PURPOSE
//  Shares one programmable UDP truth-table evaluator among NREQ requesters.
//  Each requester submits an NIN-bit input vector; the block round-robin arbitrates,
//  looks up the table entry and returns a 3-valued output (0/1/x) tagged with the requester id.
//  The table itself is written through a config port.
//  Sits between gate-level simulation clients and the shared primitive table store.
// PARAMETERS
//  NREQ  4  number of requesters (>=2)
//  NIN   2  UDP input count; table depth = 2**NIN entries
//  IDW   2  requester id width, $clog2(NREQ)
// PORTS
//  clk        in   1         rising-edge clock
//  rst        in   1         synchronous active-high reset
//  req_valid  in   NREQ      per-requester lookup request
//  req_in     in   NREQ*NIN  input vectors, requester k at [k*NIN +: NIN]
//  req_ready  out  NREQ      one-hot accept; a request is taken when valid & ready
//  rsp_valid  out  1         response available
//  rsp_ready  in   1         consumer accepts response
//  rsp_id     out  IDW       requester id of response
//  rsp_out    out  2         2'b00=0, 2'b01=1, 2'b1x=x
//  cfg_we     in   1         table write strobe
//  cfg_addr   in   NIN       table entry index
//  cfg_data   in   2         entry value, same encoding as rsp_out
//  cfg_ready  out  1         write accepted this cycle when cfg_we & cfg_ready
// BEHAVIOUR
//  - Reset: state=IDLE; rr pointer=0; req_ready=0; rsp_valid=0; rsp_id=0; rsp_out=2'b10; cfg_ready=1.
//  - Table: NIN-indexed register array of 2-bit entries.
//    Reset contents are set by the macro (see CONFIGURATION).
//  - FSM IDLE -> LOOK -> RESP -> IDLE.
//  - IDLE:
//    - cfg_ready=1.
//    - If cfg_we: write entry, stay IDLE, grant nothing. Config has priority over requests.
//    - Else if any req_valid: grant the first valid requester at or after the rr pointer (wrapping).
//      req_ready is one-hot on that index for this cycle only.
//      Latch id and input vector; go to LOOK.
//  - LOOK:
//    - cfg_ready=0. Register the table[latched_in] read into rsp_out.
//    - rsp_id = latched id; rsp_valid=1; go to RESP.
//  - RESP:
//    - cfg_ready=0. Hold rsp_* stable while rsp_valid & !rsp_ready.
//    - On rsp_ready: rsp_valid=0; rr pointer = granted id + 1 (mod NREQ); go to IDLE.
//  - Latency: accept cycle N -> rsp_valid in cycle N+2.
//    Max throughput is 1 lookup per 3 cycles with rsp_ready tied high.
//  - A requester not granted keeps req_ready=0 and must hold its valid/data. No request is dropped.
//  - Simultaneous cfg_we and req_valid in IDLE: the write wins; the request is granted next idle cycle.
//  - cfg_we outside IDLE: ignored (cfg_ready=0). The writer must hold it.
//  - Response value reflects the table contents at the LOOK cycle.
//  - rst mid-operation: any state returns to IDLE next edge. An in-flight response is discarded.
//    The table is reinitialised.
//  - rr pointer wraps NREQ-1 -> 0. Fairness: no requester waits more than NREQ grants.
// CONFIGURATION
//  UDP_TBL_DEFAULT_INV_EN defined:
//    - Reset loads entry i = {1'b0, ~i[0]}, an inverter on input 0 (i=0 ->1, i=1 ->0).
//  Not defined:
//    - Reset loads every entry = 2'b10 (x).
//    - Lookups before programming return x.
// TESTING
//  1. Macro on, NREQ=4, NIN=2:
//     req_valid=4'b0001, req_in[1:0]=0 -> req_ready=0001 same cycle.
//     Two cycles later rsp_valid=1, rsp_id=0, rsp_out=2'b01.
//  2. Macro off:
//     cfg_we addr=3 data=00 (cfg_ready=1); then req1 in=3 -> rsp_id=1, rsp_out=00.
//     req1 in=2 -> rsp_out=2'b10.
//  3. All four valid continuously, rsp_ready=1:
//     grants 0,1,2,3,0 in that order; each 3 cycles apart.
//  4. Backpressure: rsp_ready=0 for 5 cycles in RESP:
//     rsp_* stable, no req_ready, cfg_ready=0; release -> IDLE next cycle.
//  5. Same cycle as req_valid=0010 in IDLE, cfg_we addr=1 data=01:
//     write taken, req_ready=0; next cycle req_ready=0010; rsp_out reflects the new value.
//  6. rst asserted in LOOK:
//     next cycle rsp_valid=0, cfg_ready=1, rr pointer=0, table back to reset contents.

Source files
------------

// File: rtl/udp_table_sched.sv
// -----------------------------------------------------------------------------
// udp_table_sched
//   Shares one programmable UDP truth-table evaluator among NREQ requesters.
//   Requests are granted round-robin. The granted input vector is looked up in
//   a 2**NIN-entry table of 3-valued outputs (2'b00=0, 2'b01=1, 2'b1x=x). The
//   result is returned tagged with the requester id. The table is written
//   through a config port, which is only open while the block is idle.
//
// Optional feature macro: UDP_TBL_DEFAULT_INV_EN
//   defined     : reset loads an inverter on input 0 (entry i = {1'b0, ~i[0]})
//   not defined : reset loads every entry with x (2'b10)
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   req_valid     per-requester lookup request
//   req_in        input vectors, requester k at [k*NIN +: NIN]
//   req_ready     one-hot accept, combinational in IDLE (taken when valid&ready)
//   rsp_valid     response available (held until rsp_ready)
//   rsp_ready     consumer accepts response
//   rsp_id        requester id of the response
//   rsp_out       looked-up table value
//   cfg_we        table write strobe
//   cfg_addr      table entry index
//   cfg_data      entry value
//   cfg_ready     write accepted this cycle when cfg_we & cfg_ready
// -----------------------------------------------------------------------------
module udp_table_sched #(
  parameter int NREQ = 4,
  parameter int NIN  = 2,
  parameter int IDW  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*NIN-1:0]   req_in,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [1:0]            rsp_out,
  input  logic                  cfg_we,
  input  logic [NIN-1:0]        cfg_addr,
  input  logic [1:0]            cfg_data,
  output logic                  cfg_ready
);

  localparam int DEPTH = 2 ** NIN;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOOK = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [NIN-1:0]  in_q, in_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [1:0]      rsp_out_q, rsp_out_d;
  logic            cfg_ready_q, cfg_ready_d;
  logic [1:0]      tbl_q [DEPTH];
  logic [1:0]      tbl_d [DEPTH];

  logic            grant_found_s;
  logic [IDW-1:0]  grant_idx_s;
  logic [NREQ-1:0] req_ready_s;
  int              cand_s;

  // Round-robin successor of a requester id, wrapping NREQ-1 -> 0.
  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    if (id == IDW'(NREQ - 1)) begin
      return {IDW{1'b0}};
    end else begin
      return id + IDW'(1);
    end
  endfunction

  // Round-robin search: first valid requester at or after the rr pointer.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = {IDW{1'b0}};
    cand_s        = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = int'(rr_q) + k;
      if (cand_s >= NREQ) begin
        cand_s = cand_s - NREQ;
      end else begin
        cand_s = cand_s;
      end
      if (!grant_found_s && req_valid[cand_s]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = IDW'(cand_s);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // One-hot accept only in IDLE and only when no config write claims the cycle.
  always_comb begin
    req_ready_s = {NREQ{1'b0}};
    if ((state_q == ST_IDLE) && !cfg_we && grant_found_s) begin
      for (int i = 0; i < NREQ; i++) begin
        req_ready_s[i] = (IDW'(i) == grant_idx_s);
      end
    end else begin
      req_ready_s = {NREQ{1'b0}};
    end
  end

  // Next-state and datapath logic for the IDLE -> LOOK -> RESP sequence.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    id_d        = id_q;
    in_d        = in_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_out_d   = rsp_out_q;
    tbl_d       = tbl_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_we) begin
          // Config wins over requests; the request is served next idle cycle.
          tbl_d[cfg_addr] = cfg_data;
        end else if (grant_found_s) begin
          id_d    = grant_idx_s;
          in_d    = req_in[int'(grant_idx_s)*NIN +: NIN];
          state_d = ST_LOOK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOOK: begin
        rsp_out_d   = tbl_q[in_q];
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_d        = next_id(id_q);
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Config port is open exactly while the block sits in IDLE.
    cfg_ready_d = (state_d == ST_IDLE);
  end

  // State, response and table registers; reset also reinitialises the table.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_q        <= {IDW{1'b0}};
      id_q        <= {IDW{1'b0}};
      in_q        <= {NIN{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= {IDW{1'b0}};
      rsp_out_q   <= 2'b10;
      cfg_ready_q <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
`ifdef UDP_TBL_DEFAULT_INV_EN
        tbl_q[i] <= {1'b0, ~i[0]};
`else
        tbl_q[i] <= 2'b10;
`endif
      end
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      id_q        <= id_d;
      in_q        <= in_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_out_q   <= rsp_out_d;
      cfg_ready_q <= cfg_ready_d;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= tbl_d[i];
      end
    end
  end

  assign req_ready = req_ready_s;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_out   = rsp_out_q;
  assign cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_udp_table_sched.sv
// -----------------------------------------------------------------------------
// tb_udp_table_sched
//   Self-checking bench for udp_table_sched (NREQ=4, NIN=2). A reference model
//   clocked on the falling edge predicts req_ready/cfg_ready/rsp_valid every
//   cycle and pushes expected {id, value} responses into a scoreboard queue at
//   grant time; responses are compared against the queue head while in RESP.
//   Inputs are driven 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_udp_table_sched;

  localparam int NREQ = 4;
  localparam int NIN  = 2;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*NIN-1:0] req_in;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [1:0]          rsp_out;
  logic                cfg_we;
  logic [NIN-1:0]      cfg_addr;
  logic [1:0]          cfg_data;
  logic                cfg_ready;

  udp_table_sched #(.NREQ(NREQ), .NIN(NIN), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_in(req_in), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_out(rsp_out),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(cfg_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [1:0]     val;
  } exp_t;

  int              n_cmp = 0;
  int              n_bad = 0;
  exp_t            sb[$];
  logic [1:0]      tbl_m [1 << NIN];
  int              m_st;
  logic [IDW-1:0]  rr_m;
  logic [IDW-1:0]  id_m;
  logic            mon_en = 1'b0;
  logic [NREQ-1:0] acc_mask = '0;
  logic            cfg_acc = 1'b0;
  int              cyc = 0;
  int              g_cyc[$];
  logic [NREQ-1:0] g_val[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [1:0] reset_entry(input int i);
`ifdef UDP_TBL_DEFAULT_INV_EN
    return {1'b0, ~i[0]};
`else
    return 2'b10;
`endif
  endfunction

  task automatic model_reset();
    m_st = 0;
    rr_m = '0;
    id_m = '0;
    for (int i = 0; i < (1 << NIN); i++) tbl_m[i] = reset_entry(i);
    sb.delete();
  endtask

  // Reference model step: predict this cycle's outputs, check, then advance.
  task automatic model_step();
    logic [NREQ-1:0] e_rdy;
    logic            e_cfg;
    logic            e_vld;
    logic            found;
    int              g;
    int              idx;
    exp_t            e;
    cyc++;
    e_rdy = '0; e_cfg = 1'b0; e_vld = 1'b0; found = 1'b0; g = 0;
    acc_mask = req_valid & req_ready;
    cfg_acc  = cfg_we & cfg_ready;
    if (req_ready != '0) begin
      g_cyc.push_back(cyc);
      g_val.push_back(req_ready);
    end
    case (m_st)
      0: begin
        e_cfg = 1'b1;
        if (!cfg_we) begin
          for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_m) + k) % NREQ;
            if (!found && req_valid[idx]) begin
              found = 1'b1;
              g = idx;
            end
          end
          if (found) e_rdy[g] = 1'b1;
        end
      end
      2: e_vld = 1'b1;
      default: ;
    endcase
    if (mon_en) begin
      check_eq("req_ready", req_ready, e_rdy);
      check_eq("cfg_ready", cfg_ready, e_cfg);
      check_eq("rsp_valid", rsp_valid, e_vld);
      if (m_st == 2) begin
        if (sb.size() == 0) begin
          check_eq("sb_nonempty", 0, 1);
        end else begin
          check_eq("rsp_id", rsp_id, sb[0].id);
          check_eq("rsp_out", rsp_out, sb[0].val);
        end
      end
    end
    if (rst) begin
      model_reset();
    end else begin
      case (m_st)
        0: begin
          if (cfg_we) begin
            tbl_m[cfg_addr] = cfg_data;
          end else if (found) begin
            e.id  = IDW'(g);
            e.val = tbl_m[req_in[g*NIN +: NIN]];
            sb.push_back(e);
            id_m = IDW'(g);
            m_st = 1;
          end
        end
        1: m_st = 2;
        2: begin
          if (rsp_ready) begin
            if (sb.size() != 0) void'(sb.pop_front());
            rr_m = (id_m == IDW'(NREQ - 1)) ? '0 : id_m + 1'b1;
            m_st = 0;
          end
        end
        default: m_st = 0;
      endcase
    end
  endtask

  always @(negedge clk) model_step();

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until requester idx is accepted, then return after that edge.
  task automatic req_wait(input int idx, input string tag);
    int n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!acc_mask[idx] && n < 40);
    check_eq({tag, "_accept"}, acc_mask[idx], 1'b1);
    tick();
  endtask

  task automatic cfg_write(input logic [NIN-1:0] a, input logic [1:0] d, input string tag);
    int n = 0;
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    do begin
      @(negedge clk); #1; n++;
    end while (!cfg_acc && n < 40);
    check_eq({tag, "_cfg_accept"}, cfg_acc, 1'b1);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    check_eq({tag, "_drain"}, sb.size(), 0);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_in = '0; rsp_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    model_reset();
    tick(); tick();
    // Reset values (sampled while reset still held).
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_rsp_id", rsp_id, 2'b00);
    check_eq("rst_rsp_out", rsp_out, 2'b10);
    check_eq("rst_cfg_ready", cfg_ready, 1'b1);
    check_eq("rst_req_ready", req_ready, 4'b0000);
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // 1: single request from requester 0, input 0.
    req_valid = 4'b0001; req_in[1:0] = 2'd0;
    req_wait(0, "t1");
    req_valid = '0;
    drain("t1");

    // 2: program entry 3 = 0, then look up 3 and the unprogrammed 2.
    cfg_write(2'd3, 2'b00, "t2");
    req_valid = 4'b0010; req_in[3:2] = 2'd3;
    req_wait(1, "t2a");
    req_valid = '0;
    drain("t2a");
    req_valid = 4'b0010; req_in[3:2] = 2'd2;
    req_wait(1, "t2b");
    req_valid = '0;
    drain("t2b");

    // 5: write and request in the same idle cycle; write wins.
    req_valid = 4'b0010; req_in[3:2] = 2'd1;
    cfg_write(2'd1, 2'b01, "t5");
    req_wait(1, "t5");
    req_valid = '0;
    drain("t5");

    // 4: backpressure in RESP with a pending request and a pending write.
    rsp_ready = 1'b0;
    req_valid = 4'b0001; req_in[1:0] = 2'd3;
    req_wait(0, "t4");
    req_valid = 4'b0100; req_in[5:4] = 2'd1;
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 2'b01;
    for (int i = 0; i < 7; i++) tick();
    check_eq("t4_hold_valid", rsp_valid, 1'b1);
    check_eq("t4_hold_cfg_ready", cfg_ready, 1'b0);
    cfg_we = 1'b0;
    rsp_ready = 1'b1;
    req_wait(2, "t4");
    req_valid = '0;
    drain("t4");

    // 6: reset in LOOK discards the lookup and restores the table.
    req_valid = 4'b1000; req_in[7:6] = 2'd0;
    req_wait(3, "t6");
    rst = 1'b1; req_valid = '0;
    tick();
    rst = 1'b0;
    check_eq("t6_rsp_valid", rsp_valid, 1'b0);
    check_eq("t6_cfg_ready", cfg_ready, 1'b1);
    req_valid = 4'b0001; req_in[1:0] = 2'd1;
    req_wait(0, "t6b");
    req_valid = '0;
    drain("t6b");

    // 3: all four requesting continuously: 0,1,2,3,0 three cycles apart.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    g_cyc.delete(); g_val.delete();
    req_in = 8'b11_10_01_00;
    req_valid = 4'b1111;
    for (int i = 0; i < 40 && g_val.size() < 5; i++) tick();
    req_valid = '0;
    check_eq("t3_grants", g_val.size(), 5);
    if (g_val.size() >= 5) begin
      check_eq("t3_g0", g_val[0], 4'b0001);
      check_eq("t3_g1", g_val[1], 4'b0010);
      check_eq("t3_g2", g_val[2], 4'b0100);
      check_eq("t3_g3", g_val[3], 4'b1000);
      check_eq("t3_g4", g_val[4], 4'b0001);
      for (int i = 1; i < 5; i++) check_eq("t3_spacing", g_cyc[i] - g_cyc[i-1], 3);
    end
    drain("t3");

    // Random traffic: requesters and writer hold until accepted.
    for (int c = 0; c < 300; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (acc_mask[k] || !req_valid[k]) begin
          req_valid[k] = ($urandom_range(0, 2) == 0);
          req_in[k*NIN +: NIN] = NIN'($urandom_range(0, 3));
        end
      end
      if (cfg_acc) cfg_we = 1'b0;
      if (!cfg_we && $urandom_range(0, 7) == 0) begin
        cfg_we = 1'b1;
        cfg_addr = NIN'($urandom_range(0, 3));
        cfg_data = 2'($urandom_range(0, 2));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = '0; cfg_we = 1'b0; rsp_ready = 1'b1;
    drain("rand");
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
